// File: rtl/env_follower_if.sv
// Sample/config bus into the envelope follower and the envelope/gate result bus out of it.
interface env_follower_if;
  logic       sample_valid;
  logic [7:0] sample;
  logic [7:0] ai;
  logic [7:0] ri;
  logic [7:0] thr_on;
  logic [7:0] thr_off;
  logic [7:0] hold;
  logic [7:0] envelope;
  logic       gate;
  logic       env_valid;

  modport master (
    output sample_valid, sample, ai, ri, thr_on, thr_off, hold,
    input  envelope, gate, env_valid
  );

  modport slave (
    input  sample_valid, sample, ai, ri, thr_on, thr_off, hold,
    output envelope, gate, env_valid
  );
endinterface

// File: rtl/env_follower.sv
// Peak envelope follower with attack/release slew limits and a hysteretic note gate with hold.
module env_follower (
  input  logic          clk,
  input  logic          rst,
  env_follower_if.slave bus
);
  localparam int unsigned DW = 8;
  localparam int unsigned MW = 7;

  typedef enum logic [1:0] {
    S_OFF  = 2'b00,
    S_ON   = 2'b01,
    S_HOLD = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] env_q, env_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          gate_q, gate_d;
  logic          vld_q;

  logic [MW-1:0]        mag_c;
  logic [DW:0]          sum_c;
  logic signed [DW+1:0] diff_c;
  logic [DW-1:0]        new_env_c;

  // |sample| with -128 clamped to 127
  always_comb begin
    mag_c = '0;
    if (bus.sample == 8'h80) begin
      mag_c = 7'h7f;
    end else if (bus.sample[DW-1]) begin
      mag_c = MW'(~bus.sample + 8'd1);
    end else begin
      mag_c = MW'(bus.sample);
    end
  end

  // Slew-limited step toward mag; widened arithmetic keeps the clamp exact
  always_comb begin
    sum_c     = {1'b0, env_q} + {1'b0, bus.ai};
    diff_c    = $signed({2'b00, env_q}) - $signed({2'b00, bus.ri});
    new_env_c = env_q;
    if ({1'b0, mag_c} > env_q) begin
      new_env_c = (sum_c > {2'b00, mag_c}) ? {1'b0, mag_c} : sum_c[DW-1:0];
    end else if ({1'b0, mag_c} < env_q) begin
      new_env_c = (diff_c < $signed({3'b000, mag_c})) ? {1'b0, mag_c} : diff_c[DW-1:0];
    end
  end

  // Gate FSM next state; decisions use this edge's new envelope
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    env_d   = env_q;
    if (bus.sample_valid) begin
      env_d = new_env_c;
    end
    case (state_q)
      S_OFF: begin
        if (bus.sample_valid && (new_env_c >= bus.thr_on)) begin
          state_d = S_ON;
        end
      end
      S_ON: begin
        if (bus.sample_valid && (new_env_c < bus.thr_off)) begin
          state_d = (bus.hold == '0) ? S_OFF : S_HOLD;
          cnt_d   = bus.hold;
        end
      end
      S_HOLD: begin
        if (bus.sample_valid) begin
          if (new_env_c >= bus.thr_on) begin
            state_d = S_ON;
            cnt_d   = '0;
          end else if (cnt_q <= 8'd1) begin
            state_d = S_OFF;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = '0;
      end
    endcase
    gate_d = (state_d == S_ON) || (state_d == S_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      env_q   <= '0;
      gate_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      env_q   <= env_d;
      gate_q  <= gate_d;
      vld_q   <= bus.sample_valid;
    end
  end

  assign bus.envelope  = env_q;
  assign bus.gate      = gate_q;
  assign bus.env_valid = vld_q;
endmodule
